// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg : shared constants, state type and hex glyphs for the scanner
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

`default_nettype wire

// File: rtl/hex_to_7seg.sv
// ---------------------------------------------------------------------------
// hex_to_7seg : combinational nibble to active-low seven-segment glyph
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (hex)
      4'h0: seg_n = GLYPH_0;
      4'h1: seg_n = GLYPH_1;
      4'h2: seg_n = GLYPH_2;
      4'h3: seg_n = GLYPH_3;
      4'h4: seg_n = GLYPH_4;
      4'h5: seg_n = GLYPH_5;
      4'h6: seg_n = GLYPH_6;
      4'h7: seg_n = GLYPH_7;
      4'h8: seg_n = GLYPH_8;
      4'h9: seg_n = GLYPH_9;
      4'hA: seg_n = GLYPH_A;
      4'hB: seg_n = GLYPH_B;
      4'hC: seg_n = GLYPH_C;
      4'hD: seg_n = GLYPH_D;
      4'hE: seg_n = GLYPH_E;
      4'hF: seg_n = GLYPH_F;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl : 4-digit multiplexed 7-seg scanner with valid/ready load
//                     and frame-aligned update. Option: DISPLAY_LEADING_ZERO_BLANK_EN
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_number,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n
);

  localparam int PRE_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int DIG_W = $clog2(NUM_DIGITS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

  scan_state_t      state, state_next;
  logic [PRE_W-1:0] prescaler;
  logic [DIG_W-1:0] digit;
  logic             pending;
  logic [15:0]      pending_num;
  logic [15:0]      display_num;
  logic             tick;
  logic             frame_end;
  logic             load_display;
  logic             accept;
  logic [3:0]       nibble;
  logic [6:0]       glyph;
  logic             blank_digit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable)  state_next = SCAN;
      SCAN:    if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign tick         = (state == SCAN) && (prescaler == PRE_LAST);
  assign frame_end    = tick && (digit == DIG_LAST);
  // Updates only land between frames so a number is never shown half old/half new.
  assign load_display = pending && ((state == IDLE) || frame_end);
  assign in_ready     = !pending;
  assign accept       = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      digit     <= '0;
    end else if (state == IDLE) begin
      prescaler <= '0;
      digit     <= '0;
    end else if (tick) begin
      prescaler <= '0;
      digit     <= digit + DIG_W'(1);
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending     <= 1'b0;
      pending_num <= '0;
      display_num <= '0;
    end else if (load_display) begin
      pending     <= 1'b0;
      display_num <= pending_num;
    end else if (accept) begin
      pending     <= 1'b1;
      pending_num <= in_number;
    end
  end

  always_comb begin
    nibble = display_num[3:0];
    case (digit)
      2'd0:    nibble = display_num[15:12];
      2'd1:    nibble = display_num[11:8];
      2'd2:    nibble = display_num[7:4];
      default: nibble = display_num[3:0];
    endcase
  end

  hex_to_7seg u_hex_to_7seg (
    .hex   (nibble),
    .seg_n (glyph)
  );

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
  // Blank a digit when it and every digit to its left are zero; rightmost always shown.
  always_comb begin
    blank_digit = 1'b0;
    case (digit)
      2'd0:    blank_digit = (display_num[15:12] == 4'h0);
      2'd1:    blank_digit = (display_num[15:8]  == 8'h00);
      2'd2:    blank_digit = (display_num[15:4]  == 12'h000);
      default: blank_digit = 1'b0;
    endcase
  end
`else
  assign blank_digit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_n  <= AN_OFF;
      seg_n <= SEG_BLANK;
    end else if ((state == SCAN) && enable) begin
      an_n  <= ~(4'b1000 >> digit);
      seg_n <= blank_digit ? SEG_BLANK : glyph;
    end else begin
      an_n  <= AN_OFF;
      seg_n <= SEG_BLANK;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_display_scan_ctrl : self-checking bench for display_scan_ctrl (REFRESH_DIV=4)
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_display_scan_ctrl;

  localparam int DIV = 4;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_number;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;

  always #5 clk = ~clk;

  display_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_number (in_number),
    .an_n      (an_n),
    .seg_n     (seg_n)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } obs_t;

  typedef struct packed {
    logic [15:0]     num;
    logic [0:3][6:0] seg;
  } vec_t;

  obs_t sb[$];
  obs_t mon_e;
  vec_t vecs[7];
  logic       mon_en = 1'b0;
  logic [3:0] prev_an = 4'hF;
  int         since = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [6:0] apply_blank(input logic [15:0] num, input int i, input logic [6:0] s);
    if (LZB && i < 3 && (num >> (12 - 4 * i)) == 16'h0) return 7'h7F;
    return s;
  endfunction

  task automatic push_segs(input logic [15:0] num, input logic [0:3][6:0] segs);
    obs_t o;
    for (int i = 0; i < 4; i++) begin
      o.an  = ~(4'b1000 >> i);
      o.seg = apply_blank(num, i, segs[i]);
      sb.push_back(o);
    end
  endtask

  task automatic push_frame(input logic [15:0] num);
    logic [0:3][6:0] segs;
    for (int i = 0; i < 4; i++) segs[i] = glyph(num[15 - 4 * i -: 4]);
    push_segs(num, segs);
  endtask

  // Scoreboard monitor: every new lit anode pops one expected digit slot.
  always @(negedge clk) begin
    if (mon_en && an_n !== prev_an && an_n !== 4'hF) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_underflow: got an_n=%h seg_n=%h, expected no output", an_n, seg_n);
      end else begin
        mon_e = sb.pop_front();
        check("an_n", {28'd0, an_n}, {28'd0, mon_e.an});
        check("seg_n", {25'd0, seg_n}, {25'd0, mon_e.seg});
      end
      if (prev_an !== 4'hF) check("digit_period", since, DIV);
      since = 1;
    end else begin
      since++;
    end
    if (mon_en && an_n !== 4'hF) check("one_anode", $countones(~an_n), 1);
    prev_an = an_n;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_idle(input logic [15:0] num);
    in_valid  = 1'b1;
    in_number = num;
    cyc();
    in_valid = 1'b0;
    check("ready_after_accept", {31'd0, in_ready}, 32'd0);
    cyc();
  endtask

  task automatic run_frame();
    enable = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    enable = 1'b0;
    cyc();
    cyc();
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h12AF, {7'h79, 7'h24, 7'h08, 7'h0E}};
    vecs[1] = '{16'h0050, {7'h40, 7'h40, 7'h12, 7'h40}};
    vecs[2] = '{16'h8888, {7'h00, 7'h00, 7'h00, 7'h00}};
    vecs[3] = '{16'h3467, {7'h30, 7'h19, 7'h02, 7'h78}};
    vecs[4] = '{16'h9BCD, {7'h10, 7'h03, 7'h46, 7'h21}};
    vecs[5] = '{16'h0E00, {7'h40, 7'h06, 7'h40, 7'h40}};
    vecs[6] = '{16'h0000, {7'h40, 7'h40, 7'h40, 7'h40}};

    reset_n   = 1'b0;
    enable    = 1'b0;
    in_valid  = 1'b0;
    in_number = 16'h0;
    @(negedge clk);
    check("reset_an", {28'd0, an_n}, 32'hF);
    check("reset_seg", {25'd0, seg_n}, 32'h7F);
    check("reset_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    reset_n = 1'b1;
    cyc();

    // Table-driven frames
    mon_en = 1'b1;
    for (int v = 0; v < 7; v++) begin
      load_idle(vecs[v].num);
      push_segs(vecs[v].num, vecs[v].seg);
      run_frame();
    end

    // Handshake: pending value waits for frame end, next value one cycle later
    load_idle(16'h1111);
    push_frame(16'h1111);
    push_frame(16'h2222);
    push_frame(16'h3333);
    in_valid  = 1'b1;
    in_number = 16'h2222;
    enable    = 1'b1;
    cyc();
    check("ready_low_2222", {31'd0, in_ready}, 32'd0);
    in_number = 16'h3333;
    begin
      int lows;
      lows = 0;
      while (in_ready == 1'b0 && lows < 40) begin
        cyc();
        lows++;
      end
      check("ready_low_cycles", lows, 16);
    end
    cyc();
    check("third_accepted", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    enable = 1'b0;
    cyc();
    cyc();
    check("sb_drained_hs", sb.size(), 0);
    mon_en = 1'b0;

    // Enable drop during digit 2, then restart from digit 0
    enable = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("drop_pre_an", {28'd0, an_n}, 32'hD);
    enable = 1'b0;
    @(negedge clk);
    check("drop_blank_an", {28'd0, an_n}, 32'hF);
    check("drop_blank_seg", {25'd0, seg_n}, 32'h7F);
    enable = 1'b1;
    @(negedge clk);
    check("restart_first_blank", {28'd0, an_n}, 32'hF);
    @(negedge clk);
    check("restart_an", {28'd0, an_n}, 32'h7);
    check("restart_seg", {25'd0, seg_n}, {25'd0, glyph(4'h3)});
    enable = 1'b0;
    cyc();
    cyc();

    // Asynchronous reset mid-scan with a value pending
    enable    = 1'b1;
    in_valid  = 1'b1;
    in_number = 16'h4321;
    cyc();
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("prereset_ready", {31'd0, in_ready}, 32'd0);
    check("prereset_an", {28'd0, an_n}, 32'hB);
    #2;
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    check("async_an", {28'd0, an_n}, 32'hF);
    check("async_seg", {25'd0, seg_n}, 32'h7F);
    check("async_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    cyc();
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_reset_an", {28'd0, an_n}, 32'hF);
    check("post_reset_seg", {25'd0, seg_n}, 32'h7F);

    // in_valid during reset must not be captured; display must read zero
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_number = 16'hABCD;
    cyc();
    cyc();
    reset_n  = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("reset_valid_ready", {31'd0, in_ready}, 32'd1);
    mon_en = 1'b1;
    push_frame(16'h0000);
    run_frame();
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
